// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: registered RV32I/RV64I decode stage with optional 2-entry skid buffer.
module instruction_decode_stage #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32,
    parameter int SKID     = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [6:0]          out_opcode,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [XLEN-1:0]     out_imm,
    output logic [2:0]          out_fmt,
    output logic                out_illegal
);
    localparam bit RV64 = (XLEN == 64);
    localparam logic [2:0] F_X = 3'd0, F_R = 3'd1, F_I = 3'd2, F_S = 3'd3, F_B = 3'd4, F_U = 3'd5, F_J = 3'd6;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN-1:0]     imm;
        logic [2:0]          fmt;
        logic                illegal;
    } entry_t;

    entry_t d, m, s;
    logic mv, sv, acc, shift, bad_r, bad_sh;
    logic [6:0] op, f7;
    logic [2:0] f3, fmt;
    logic [31:0] i, imm32;

    always_comb begin
        i   = in_instr;
        op  = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        fmt = (op == 7'b0110011 || (RV64 && op == 7'b0111011)) ? F_R :
              (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 || op == 7'b0001111 ||
               op == 7'b1110011 || (RV64 && op == 7'b0011011)) ? F_I :
              (op == 7'b0100011) ? F_S :
              (op == 7'b1100011) ? F_B :
              (op == 7'b0110111 || op == 7'b0010111) ? F_U :
              (op == 7'b1101111) ? F_J : F_X;
        imm32 = fmt == F_I ? {{20{i[31]}}, i[31:20]} :
                fmt == F_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
                fmt == F_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
                fmt == F_U ? {i[31:12], 12'b0} :
                fmt == F_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'b0;
        bad_r  = (f7 != 7'b0000000 && f7 != 7'b0100000) || (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101);
        // word shifts (0011011) only ever have a 5-bit shamt
        shift  = (op == 7'b0010011 || op == 7'b0011011) && (f3 == 3'b001 || f3 == 3'b101);
        bad_sh = (op == 7'b0011011 || !RV64) ? (f7 != 7'b0000000 && f7 != 7'b0100000)
                                             : (i[31:26] != 6'b000000 && i[31:26] != 6'b010000);
        d.pc      = in_pc;
        d.opcode  = op;
        d.funct3  = f3;
        d.funct7  = f7;
        d.rs1     = i[19:15];
        d.rs2     = i[24:20];
        d.rd      = i[11:7];
        d.imm     = XLEN'($signed(imm32));
        d.fmt     = fmt;
        d.illegal = i[1:0] != 2'b11 || fmt == F_X ||
                    (fmt == F_R && bad_r) ||
                    (shift && bad_sh) ||
                    (op == 7'b1100011 && (f3 == 3'b010 || f3 == 3'b011)) ||
                    (op == 7'b0000011 && (f3 == 3'b111 || (!RV64 && (f3 == 3'b011 || f3 == 3'b110)))) ||
                    (op == 7'b0100011 && (RV64 ? f3 > 3'b011 : f3 > 3'b010)) ||
                    (op == 7'b1100111 && f3 != 3'b000);
    end

    assign in_ready = (SKID != 0) ? !sv : (!mv || out_ready);
    assign acc      = in_valid && in_ready && !flush;

    // skid only fills while main is stalled; with SKID=0 in_ready is low then, so it stays empty
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            mv <= 1'b0;
            sv <= 1'b0;
            m  <= '0;
            s  <= '0;
        end else if (flush) begin
            mv <= 1'b0;
            sv <= 1'b0;
        end else if (!mv || out_ready) begin
            mv <= sv || acc;
            sv <= 1'b0;
            if (sv) m <= s;
            else if (acc) m <= d;
        end else if (acc) begin
            sv <= 1'b1;
            s  <= d;
        end

    assign out_valid   = mv;
    assign out_pc      = m.pc;
    assign out_opcode  = m.opcode;
    assign out_funct3  = m.funct3;
    assign out_funct7  = m.funct7;
    assign out_rs1     = m.rs1;
    assign out_rs2     = m.rs2;
    assign out_rd      = m.rd;
    assign out_imm     = m.imm;
    assign out_fmt     = m.fmt;
    assign out_illegal = m.illegal;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb_instruction_decode_stage: directed checks of decode, skid handshake, flush and async reset.
module tb_instruction_decode_stage;
    logic clk = 0, rstn = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_instr = 0, in_pc = 0;
    logic a_in_ready, a_out_valid, a_ill, b_in_ready, b_out_valid, b_ill;
    logic [31:0] a_pc, b_pc, a_imm;
    logic [63:0] b_imm;
    logic [6:0] a_op, a_f7, b_op, b_f7;
    logic [2:0] a_f3, a_fmt, b_f3, b_fmt;
    logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    instruction_decode_stage #(.XLEN(32), .PC_WIDTH(32), .SKID(1)) dut32 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_opcode(a_op), .out_funct3(a_f3), .out_funct7(a_f7), .out_rs1(a_rs1),
        .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_ill));

    instruction_decode_stage #(.XLEN(64), .PC_WIDTH(32), .SKID(0)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_opcode(b_op), .out_funct3(b_f3), .out_funct7(b_f7), .out_rs1(b_rs1),
        .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_ill));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1;
        #1;
        check("rst_valid", a_out_valid, 0);
        check("rst_ready", a_in_ready, 1);
        check("rst_imm", a_imm, 0);
        check("rst_fmt", a_fmt, 0);
        check("rst_ill", a_ill, 0);
        check("rst_valid64", b_out_valid, 0);

        out_ready = 1;
        send(32'hFFF00093, 32'h100);
        check("addi_valid", a_out_valid, 1);
        check("addi_fmt", a_fmt, 2);
        check("addi_rd", a_rd, 1);
        check("addi_imm", a_imm, 32'hFFFFFFFF);
        check("addi_pc", a_pc, 32'h100);
        check("addi_ill", a_ill, 0);
        check("addi_op", a_op, 7'h13);
        check("addi_imm64", b_imm, 64'hFFFFFFFFFFFFFFFF);
        send(32'hFE000EE3, 32'h104);
        check("beq_fmt", a_fmt, 4);
        check("beq_imm", a_imm, 32'hFFFFFFFC);
        check("beq_ill", a_ill, 0);
        send(32'h123452B7, 32'h108);
        check("lui_fmt", a_fmt, 5);
        check("lui_rd", a_rd, 5);
        check("lui_imm", a_imm, 32'h12345000);
        send(32'h00000000, 32'h10C);
        check("zero_ill", a_ill, 1);
        check("zero_fmt", a_fmt, 0);
        send(32'h800000B7, 32'h110);
        check("lui_neg32", a_imm, 32'h80000000);
        check("lui_neg64", b_imm, 64'hFFFFFFFF80000000);
        send(32'h0200D093, 32'h114);
        check("srli32_ill", a_ill, 1);
        check("srli64_ill", b_ill, 0);
        send(32'h00B0B023, 32'h118);
        check("sd_fmt", a_fmt, 3);
        check("sd_rs2", a_rs2, 11);
        check("sd32_ill", a_ill, 1);
        check("sd64_ill", b_ill, 0);
        send(32'h402081B3, 32'h11C);
        check("sub_fmt", a_fmt, 1);
        check("sub_f7", a_f7, 7'h20);
        check("sub_ill", a_ill, 0);
        check("sub_imm", a_imm, 0);
        send(32'h022081B3, 32'h120);
        check("mul_ill", a_ill, 1);
        send(32'h0010809B, 32'h124);
        check("addiw32_fmt", a_fmt, 0);
        check("addiw32_ill", a_ill, 1);
        check("addiw64_fmt", b_fmt, 2);
        check("addiw64_ill", b_ill, 0);
        tick();
        check("drain_valid", a_out_valid, 0);

        // skid: A, B, C with consumer stalled
        out_ready = 0;
        send(32'hFFF00093, 32'h200);
        check("noskid_ready", b_in_ready, 0);
        send(32'h00200113, 32'h204);
        check("stall_pc_a", a_pc, 32'h200);
        check("full_ready", a_in_ready, 0);
        in_valid = 1;
        in_instr = 32'h00300193;
        in_pc    = 32'h208;
        tick();
        check("hold_pc_a", a_pc, 32'h200);
        check("hold_rd_a", a_rd, 1);
        check("hold_ready", a_in_ready, 0);
        out_ready = 1;
        tick();
        check("order_b_pc", a_pc, 32'h204);
        check("order_b_rd", a_rd, 2);
        check("order_b_valid", a_out_valid, 1);
        tick();
        in_valid = 0;
        check("order_c_pc", a_pc, 32'h208);
        check("order_c_valid", a_out_valid, 1);
        tick();
        check("order_end", a_out_valid, 0);

        // flush while full
        out_ready = 0;
        send(32'hFFF00093, 32'h300);
        send(32'h00200113, 32'h304);
        check("fl_full", a_in_ready, 0);
        flush    = 1;
        in_valid = 1;
        in_instr = 32'h00300193;
        in_pc    = 32'h2F0;
        tick();
        check("fl_valid", a_out_valid, 0);
        check("fl_ready", a_in_ready, 1);
        tick();
        check("fl_drop", a_out_valid, 0);
        flush    = 0;
        in_valid = 0;
        tick();
        check("fl_nothing", a_out_valid, 0);
        out_ready = 1;
        send(32'h00400213, 32'h308);
        check("fl_next_valid", a_out_valid, 1);
        check("fl_next_pc", a_pc, 32'h308);
        tick();

        // async reset with two entries held
        out_ready = 0;
        send(32'hFFF00093, 32'h400);
        send(32'h00200113, 32'h404);
        check("ar_full", a_in_ready, 0);
        #2 rstn = 0;
        #1;
        check("ar_valid", a_out_valid, 0);
        @(negedge clk) rstn = 1;
        out_ready = 1;
        tick();
        check("ar_stale1", a_out_valid, 0);
        tick();
        check("ar_stale2", a_out_valid, 0);
        check("ar_ready", a_in_ready, 1);
        check("ar_pc", a_pc, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
